freq_flag_gen: RTL and testbench



---
 rtl/freq_flag_gen_pkg.sv | 23 ++
 rtl/freq_flag_gen_zero_cross_detector.sv | 67 ++++++
 rtl/freq_flag_gen.sv | 98 +++++++++
 tb/tb_freq_flag_gen.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/freq_flag_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module  : freq_flag_pkg
// Brief   : Shared widths, constants and state types for freq_flag_gen.
// Revision: 1.0 - initial release
// ============================================================================
package freq_flag_pkg;

  localparam int            FLAG_W   = 3;
  localparam logic [FLAG_W-1:0] FLAG_MAX = 3'd7;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } ffg_state_t;

  typedef enum logic {
    NEG = 1'b0,
    POS = 1'b1
  } sign_t;

endpackage : freq_flag_pkg
`default_nettype wire

// File: rtl/freq_flag_gen_zero_cross_detector.sv
`default_nettype none
// ============================================================================
// Module  : zero_cross_detector
// Brief   : Hysteresis-qualified zero-crossing pulse generator for audio samples.
// Revision: 1.0 - initial release
// ============================================================================
module zero_cross_detector
  import freq_flag_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int THRESH   = 256
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [SAMPLE_W-1:0] i_sample,
  input  logic                       i_valid,
  output logic                       o_crossing,
  output logic                       o_sign
);

  localparam logic signed [SAMPLE_W-1:0] c_thr_pos = SAMPLE_W'(THRESH);
  localparam logic signed [SAMPLE_W-1:0] c_thr_neg = -c_thr_pos;

  ffg_state_t r_state, w_state_nxt;
  sign_t      r_sign,  w_sign_nxt;
  logic       w_crossing;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= INIT;
      r_sign  <= NEG;
    end else begin
      r_state <= w_state_nxt;
      r_sign  <= w_sign_nxt;
    end
  end

  // The sign seen on the first sample only seeds the state; it is never a crossing.
  always_comb begin
    w_state_nxt = r_state;
    w_sign_nxt  = r_sign;
    w_crossing  = 1'b0;
    if (i_valid) begin
      case (r_state)
        INIT: begin
          w_sign_nxt  = (i_sample >= 0) ? POS : NEG;
          w_state_nxt = RUN;
        end
        RUN: begin
          if (r_sign == POS && i_sample < c_thr_neg) begin
            w_sign_nxt = NEG;
            w_crossing = 1'b1;
          end else if (r_sign == NEG && i_sample > c_thr_pos) begin
            w_sign_nxt = POS;
            w_crossing = 1'b1;
          end
        end
        default: w_state_nxt = INIT;
      endcase
    end
  end

  assign o_crossing = w_crossing;
  assign o_sign     = (r_sign == POS);

endmodule : zero_cross_detector
`default_nettype wire

// File: rtl/freq_flag_gen.sv
`default_nettype none
// ============================================================================
// Module  : freq_flag_gen
// Brief   : Windowed zero-crossing count mapped to a smoothed 3-bit level.
// Revision: 1.0 - initial release
// ============================================================================
module freq_flag_gen
  import freq_flag_pkg::*;
#(
  parameter int SAMPLE_W   = 16,
  parameter int WINDOW_LEN = 1024,
  parameter int BAND_STEP  = 64,
  parameter int THRESH     = 256,
  parameter int DECAY_EN   = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [SAMPLE_W-1:0] audio_sample,
  input  logic                       audio_valid,
  output logic [FLAG_W-1:0]          freq_flag,
  output logic                       flag_update,
  output logic [FLAG_W-1:0]          raw_level
);

  localparam int CNT_W = $clog2(WINDOW_LEN + 1);

  logic [CNT_W-1:0]  r_sample_cnt;
  logic [CNT_W-1:0]  r_cross_cnt;
  logic [FLAG_W-1:0] r_freq_flag;
  logic [FLAG_W-1:0] r_raw_level;
  logic              r_flag_update;

  logic              w_crossing;
  logic              w_sign_unused;
  logic              w_win_done;
  logic [6:0]        w_ge;
  logic [FLAG_W-1:0] w_level;

  zero_cross_detector #(
    .SAMPLE_W (SAMPLE_W),
    .THRESH   (THRESH)
  ) u_zcd (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_sample   (audio_sample),
    .i_valid    (audio_valid),
    .o_crossing (w_crossing),
    .o_sign     (w_sign_unused)
  );

  // Counters hold the final totals for one cycle after the closing sample.
  assign w_win_done = (r_sample_cnt == CNT_W'(WINDOW_LEN));

  generate
    for (genvar k = 1; k <= 7; k++) begin : g_lvl
      assign w_ge[k-1] = (32'(r_cross_cnt) >= 32'(k * BAND_STEP));
    end
  endgenerate

  always_comb begin
    w_level = '0;
    for (int k = 0; k < 7; k++) begin
      if (w_ge[k]) w_level = FLAG_W'(k + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sample_cnt  <= '0;
      r_cross_cnt   <= '0;
      r_freq_flag   <= '0;
      r_raw_level   <= '0;
      r_flag_update <= 1'b0;
    end else begin
      r_flag_update <= 1'b0;
      if (w_win_done) begin
        r_raw_level   <= w_level;
        r_flag_update <= 1'b1;
        if ((DECAY_EN != 0) && (w_level < r_freq_flag))
          r_freq_flag <= r_freq_flag - FLAG_W'(1);
        else
          r_freq_flag <= w_level;
        // A sample arriving on the restart cycle opens the new window.
        r_sample_cnt <= audio_valid ? CNT_W'(1) : '0;
        r_cross_cnt  <= (audio_valid && w_crossing) ? CNT_W'(1) : '0;
      end else if (audio_valid) begin
        r_sample_cnt <= r_sample_cnt + CNT_W'(1);
        r_cross_cnt  <= r_cross_cnt + CNT_W'(w_crossing);
      end
    end
  end

  assign freq_flag   = r_freq_flag;
  assign flag_update = r_flag_update;
  assign raw_level   = r_raw_level;

endmodule : freq_flag_gen
`default_nettype wire

// File: tb/tb_freq_flag_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_freq_flag_gen
// Brief   : Directed self-checking bench for freq_flag_gen (16-sample window).
// Revision: 1.0 - initial release
// ============================================================================
module tb_freq_flag_gen;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic signed [15:0] audio_sample = '0;
  logic               audio_valid = 1'b0;
  logic [2:0]         freq_flag;
  logic               flag_update;
  logic [2:0]         raw_level;

  int n_vec  = 0;
  int n_miss = 0;
  int upd_count = 0;
  int upd_before;

  freq_flag_gen #(
    .SAMPLE_W   (16),
    .WINDOW_LEN (16),
    .BAND_STEP  (2),
    .THRESH     (256),
    .DECAY_EN   (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .audio_sample (audio_sample),
    .audio_valid  (audio_valid),
    .freq_flag    (freq_flag),
    .flag_update  (flag_update),
    .raw_level    (raw_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (flag_update === 1'b1) upd_count <= upd_count + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Presents one valid sample, then 'gap' idle cycles.
  task automatic send(input logic signed [15:0] v, input int gap);
    @(negedge clk);
    audio_sample = v;
    audio_valid  = 1'b1;
    repeat (gap) begin
      @(negedge clk);
      audio_valid = 1'b0;
    end
  endtask

  task automatic send_alt(input int n, input logic signed [15:0] amp, input int gap);
    for (int i = 0; i < n; i++)
      send((i % 2 == 0) ? amp : -amp, (i == n - 1) ? 0 : gap);
  endtask

  // Called right after the window-closing sample has been presented.
  task automatic check_window(input string tag, input int exp_raw, input int exp_flag);
    @(negedge clk);
    audio_valid = 1'b0;
    chk({tag, "_upd_early"}, 32'(flag_update), 0);
    @(negedge clk);
    chk({tag, "_upd"},  32'(flag_update), 1);
    chk({tag, "_raw"},  32'(raw_level), 32'(exp_raw));
    chk({tag, "_flag"}, 32'(freq_flag), 32'(exp_flag));
    @(negedge clk);
    chk({tag, "_upd_end"}, 32'(flag_update), 0);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    audio_valid = 1'b0;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // 1: reset held with valid samples toggling
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      audio_valid  = 1'b1;
      audio_sample = (i == 0) ? 16'sd1000 : -16'sd1000;
      @(negedge clk);
      chk("rst_flag", 32'(freq_flag), 0);
      chk("rst_raw",  32'(raw_level), 0);
      chk("rst_upd",  32'(flag_update), 0);
    end
    audio_valid = 1'b0;
    rst_n = 1'b1;

    // 2: 15 crossings -> level 7
    send_alt(16, 16'sd1000, 0);
    check_window("s2", 7, 7);

    // 3: in-band samples -> no crossings, decay one step per window
    send_alt(16, 16'sd200, 0);
    check_window("s3a", 0, 6);
    send_alt(16, 16'sd200, 0);
    check_window("s3b", 0, 5);

    // 4: blocks of four -> crossings at samples 5, 9, 13
    do_reset(1);
    chk("s4_rst_flag", 32'(freq_flag), 0);
    for (int i = 0; i < 16; i++)
      send(((i / 4) % 2 == 0) ? 16'sd1000 : -16'sd1000, 0);
    check_window("s4", 1, 1);

    // 5: gapped valid, one sample every third cycle
    upd_before = upd_count;
    send_alt(16, 16'sd1000, 2);
    chk("s5_no_early", 32'(upd_count), 32'(upd_before));
    check_window("s5", 7, 7);

    // 6: reset mid-window discards the partial window
    upd_before = upd_count;
    send_alt(10, 16'sd1000, 0);
    do_reset(1);
    @(negedge clk);
    chk("s6_no_upd",   32'(upd_count), 32'(upd_before));
    chk("s6_rst_flag", 32'(freq_flag), 0);
    send_alt(15, 16'sd1000, 0);
    @(negedge clk);
    audio_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("s6_no_upd_15", 32'(upd_count), 32'(upd_before));
    send(-16'sd1000, 0);
    check_window("s6", 7, 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule : tb_freq_flag_gen
`default_nettype wire
